// File: rtl/frame_parser_fsm.sv
// rtl/frame_parser_fsm.sv - ingress frame parser: SFD hunt, header field walk, runt/oversize/drop handling
module frame_parser_fsm #(
  parameter int                DATA_W            = 16,
  parameter logic [DATA_W-1:0] SFD_WORD          = DATA_W'(16'hAAAB),
  parameter int                DST_WORDS         = 3,
  parameter int                SRC_WORDS         = 3,
  parameter int                TYPE_WORDS        = 1,
  parameter int                MIN_PAYLOAD_WORDS = 23,
  parameter int                MAX_FRAME_WORDS   = 759
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              drop_current,
  input  logic              almost_full,
  output logic              pkt_tvalid,
  output logic [DATA_W-1:0] pkt_tdata,
  output logic              pkt_tlast,
  output logic [4:0]        status,
  output logic [3:0]        field_idx,
  output logic              incomplete_frame,
  output logic              frame_done,
  output logic [2:0]        frame_err,
  output logic [15:0]       frame_len
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DST     = 3'd1,
    ST_SRC     = 3'd2,
    ST_TYPE    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_FLUSH   = 3'd5,
    ST_MASK    = 3'd6
  } state_t;

  localparam logic [15:0] HDR_W = 16'(DST_WORDS + SRC_WORDS + TYPE_WORDS);
  localparam logic [15:0] MIN_W = 16'(MIN_PAYLOAD_WORDS);
  localparam logic [15:0] MAX_W = 16'(MAX_FRAME_WORDS);

  state_t              state_q, state_d;
  logic [3:0]          fidx_q, fidx_d;
  logic [15:0]         len_q, len_d;
  logic [2:0]          err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                incomp_q;
  logic [4:0]          status_q;
  logic                tready_q;
  logic                pv_q;
  logic [DATA_W-1:0]   pd_q;
  logic                pl_q;

  logic [15:0]         len_inc;
  logic [15:0]         pay_cnt;
  logic [3:0]          field_last;
  state_t              field_next;

  function automatic logic [4:0] status_of(input state_t s);
    case (s)
      ST_DST:     return 5'b00011;
      ST_SRC:     return 5'b00101;
      ST_TYPE:    return 5'b01001;
      ST_PAYLOAD: return 5'b10001;
      default:    return 5'b00000;
    endcase
  endfunction

  always_comb begin
    len_inc    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    pay_cnt    = len_inc - HDR_W;
    field_last = 4'(DST_WORDS - 1);
    field_next = ST_SRC;
    if (state_q == ST_SRC) begin
      field_last = 4'(SRC_WORDS - 1);
      field_next = ST_TYPE;
    end else if (state_q == ST_TYPE) begin
      field_last = 4'(TYPE_WORDS - 1);
      field_next = ST_PAYLOAD;
    end
  end

  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    len_d   = len_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pv_q) begin
          if (pl_q) begin
            state_d = ST_FLUSH;
          end else if (pd_q == SFD_WORD) begin
            state_d = ST_DST;
            fidx_d  = 4'd0;
            len_d   = 16'd0;
            err_d   = 3'b000;
            ovf_d   = 1'b0;
          end
        end
      end
      ST_DST, ST_SRC, ST_TYPE: begin
        if (pv_q) begin
          len_d = len_inc;
          if (pl_q) begin
            state_d = ST_FLUSH;
            fidx_d  = 4'd0;
            err_d   = 3'b001;
            done_d  = 1'b1;
          end else if (fidx_q == field_last) begin
            state_d = field_next;
            fidx_d  = 4'd0;
          end else begin
            fidx_d = fidx_q + 4'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pv_q) begin
          len_d = len_inc;
          if (pl_q) begin
            state_d = ST_IDLE;
            err_d   = {len_inc > MAX_W, pay_cnt < MIN_W, 1'b0};
            done_d  = 1'b1;
          end else if (len_inc > MAX_W) begin
            state_d  = ST_MASK;
            ovf_d    = 1'b1;
            err_d[2] = 1'b1;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      ST_MASK: begin
        if (pv_q) begin
          len_d = len_inc;
          if (pl_q) begin
            state_d = ST_IDLE;
            done_d  = ovf_q;
            ovf_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        fidx_d  = 4'd0;
      end
    endcase

    // A drop order overrides everything, including an end-of-frame on the same beat.
    if (drop_current && (state_q inside {ST_DST, ST_SRC, ST_TYPE, ST_PAYLOAD, ST_FLUSH, ST_MASK})) begin
      state_d = (pv_q && pl_q) ? ST_IDLE : ST_MASK;
      fidx_d  = 4'd0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      fidx_q   <= 4'd0;
      len_q    <= 16'd0;
      err_q    <= 3'b000;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      incomp_q <= 1'b0;
      status_q <= 5'b00000;
      tready_q <= 1'b0;
      pv_q     <= 1'b0;
      pd_q     <= '0;
      pl_q     <= 1'b0;
    end else begin
      tready_q <= ~almost_full;
      pv_q     <= s_tvalid & tready_q;
      pd_q     <= s_tdata;
      pl_q     <= s_tlast;
      state_q  <= state_d;
      fidx_q   <= fidx_d;
      len_q    <= len_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      incomp_q <= (state_d == ST_FLUSH);
      status_q <= status_of(state_d);
    end
  end

  assign s_tready         = tready_q;
  assign pkt_tvalid       = pv_q;
  assign pkt_tdata        = pd_q;
  assign pkt_tlast        = pl_q;
  assign status           = status_q;
  assign field_idx        = fidx_q;
  assign incomplete_frame = incomp_q;
  assign frame_done       = done_q;
  assign frame_err        = err_q;
  assign frame_len        = len_q;

endmodule

// File: tb/tb_frame_parser_fsm.sv
// tb/tb_frame_parser_fsm.sv - scoreboard bench for frame_parser_fsm (16-bit default, 16-bit small limits, 32-bit)
module tb_frame_parser_fsm;

  localparam int HDR = 7;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [4:0]  st;
    logic [3:0]  fi;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [2:0]  err;
    logic        inc;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        drop_current;
  logic        almost_full;

  logic        tready_w [3];
  logic        pv_w     [3];
  logic        pl_w     [3];
  logic [4:0]  status_w [3];
  logic [3:0]  fidx_w   [3];
  logic        inc_w    [3];
  logic        done_w   [3];
  logic [2:0]  err_w    [3];
  logic [15:0] len_w    [3];
  logic [15:0] pd_a, pd_b;
  logic [31:0] pd_c;

  int          sel = 0;
  int          cur_min = 23;
  int          cur_max = 759;
  int          af_cnt = 0;
  int          n_tot = 0;
  int          n_bad = 0;

  logic        m_tready, m_pv, m_pl, m_inc, m_done;
  logic [4:0]  m_status;
  logic [3:0]  m_fidx;
  logic [2:0]  m_err;
  logic [15:0] m_len;
  logic [31:0] m_pd;

  beat_t       bq[$];
  frame_t      fq[$];

  always #5 clk = ~clk;

  frame_parser_fsm #(.DATA_W(16)) u_a (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata[15:0]), .s_tlast(s_tlast),
    .s_tready(tready_w[0]), .drop_current(drop_current), .almost_full(almost_full),
    .pkt_tvalid(pv_w[0]), .pkt_tdata(pd_a), .pkt_tlast(pl_w[0]), .status(status_w[0]),
    .field_idx(fidx_w[0]), .incomplete_frame(inc_w[0]), .frame_done(done_w[0]),
    .frame_err(err_w[0]), .frame_len(len_w[0]));

  frame_parser_fsm #(.DATA_W(16), .MIN_PAYLOAD_WORDS(2), .MAX_FRAME_WORDS(12)) u_b (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata[15:0]), .s_tlast(s_tlast),
    .s_tready(tready_w[1]), .drop_current(drop_current), .almost_full(almost_full),
    .pkt_tvalid(pv_w[1]), .pkt_tdata(pd_b), .pkt_tlast(pl_w[1]), .status(status_w[1]),
    .field_idx(fidx_w[1]), .incomplete_frame(inc_w[1]), .frame_done(done_w[1]),
    .frame_err(err_w[1]), .frame_len(len_w[1]));

  frame_parser_fsm #(.DATA_W(32), .SFD_WORD(32'hAAAB)) u_c (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(tready_w[2]), .drop_current(drop_current), .almost_full(almost_full),
    .pkt_tvalid(pv_w[2]), .pkt_tdata(pd_c), .pkt_tlast(pl_w[2]), .status(status_w[2]),
    .field_idx(fidx_w[2]), .incomplete_frame(inc_w[2]), .frame_done(done_w[2]),
    .frame_err(err_w[2]), .frame_len(len_w[2]));

  always_comb begin
    m_tready = tready_w[sel];
    m_pv     = pv_w[sel];
    m_pl     = pl_w[sel];
    m_status = status_w[sel];
    m_fidx   = fidx_w[sel];
    m_inc    = inc_w[sel];
    m_done   = done_w[sel];
    m_err    = err_w[sel];
    m_len    = len_w[sel];
    case (sel)
      0:       m_pd = {16'h0, pd_a};
      1:       m_pd = {16'h0, pd_b};
      default: m_pd = pd_c;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      drop_current = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [4:0] st, input logic [3:0] fi);
    beat_t b;
    bit    acc = 1'b0;
    int    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = m_tready;
      if (acc) begin
        b.d  = (sel == 2) ? d : {16'h0, d[15:0]};
        b.l  = l;
        b.st = st;
        b.fi = fi;
        bq.push_back(b);
      end
      if (af_cnt > 0) begin
        af_cnt--;
        if (af_cnt == 0) almost_full = 1'b0;
      end
      @(posedge clk);
      #1;
      drop_current = 1'b0;
      n++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int nb, input int drop_at, input int stall_at, input logic [31:0] sfd);
    frame_t     f;
    logic [4:0] st;
    logic [3:0] fi;
    logic       last, dropped;
    if (drop_at == 0) begin
      f.len = 16'(nb);
      f.inc = (nb <= HDR);
      f.err = {!f.inc && (nb > cur_max), !f.inc && ((nb - HDR) < cur_min), f.inc};
      fq.push_back(f);
    end
    send_beat(sfd, 1'b0, 5'b00011, 4'd0);
    for (int k = 1; k <= nb; k++) begin
      last    = (k == nb);
      dropped = (drop_at != 0) && (k >= drop_at);
      st = 5'b0;
      fi = 4'd0;
      if (!dropped && !last && !(k > HDR && k > cur_max)) begin
        if (k < 3) begin
          st = 5'b00011; fi = 4'(k);
        end else if (k < 6) begin
          st = 5'b00101; fi = 4'(k - 3);
        end else if (k < 7) begin
          st = 5'b01001; fi = 4'(k - 6);
        end else begin
          st = 5'b10001;
        end
      end
      if (k == stall_at) begin
        almost_full = 1'b1;
        af_cnt      = 4;
      end
      send_beat({16'h5A5A, 16'h5000 + 16'(k)}, last, st, fi);
      if (k == stall_at) check("bp_tready", 32'(m_tready), 32'd0);
      if (k == drop_at) drop_current = 1'b1;
    end
    idle(3);
  endtask

  task automatic do_reset(input int new_sel, input int mn, input int mx);
    reset        = 1'b1;
    s_tvalid     = 1'b0;
    s_tdata      = 32'h0;
    s_tlast      = 1'b0;
    drop_current = 1'b0;
    almost_full  = 1'b0;
    af_cnt       = 0;
    #1;
    sel     = new_sel;
    cur_min = mn;
    cur_max = mx;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 32'(m_tready), 32'd0);
    check("rst_pkt_tvalid", 32'(m_pv), 32'd0);
    check("rst_pkt_tdata", m_pd, 32'd0);
    check("rst_pkt_tlast", 32'(m_pl), 32'd0);
    check("rst_status", 32'(m_status), 32'd0);
    check("rst_field_idx", 32'(m_fidx), 32'd0);
    check("rst_incomplete", 32'(m_inc), 32'd0);
    check("rst_frame_done", 32'(m_done), 32'd0);
    check("rst_frame_err", 32'(m_err), 32'd0);
    check("rst_frame_len", 32'(m_len), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : monitor
    beat_t      pexp;
    beat_t      b;
    frame_t     f;
    bit         pend = 1'b0;
    logic [4:0] hold_st = 5'b0;
    logic [3:0] hold_fi = 4'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend    = 1'b0;
        hold_st = 5'b0;
        hold_fi = 4'd0;
      end else begin
        if (pend) begin
          check("status", 32'(m_status), 32'(pexp.st));
          check("field_idx", 32'(m_fidx), 32'(pexp.fi));
          hold_st = pexp.st;
          hold_fi = pexp.fi;
          pend    = 1'b0;
        end else begin
          check("hold_status", 32'(m_status), 32'(hold_st));
          check("hold_field_idx", 32'(m_fidx), 32'(hold_fi));
        end
        if (m_pv) begin
          if (bq.size() == 0) begin
            check("pkt_unexpected", 32'(m_pv), 32'd0);
          end else begin
            b = bq.pop_front();
            check("pkt_tdata", m_pd, b.d);
            check("pkt_tlast", 32'(m_pl), 32'(b.l));
            pexp = b;
            pend = 1'b1;
          end
        end
        if (m_done) begin
          if (fq.size() == 0) begin
            check("done_unexpected", 32'(m_done), 32'd0);
          end else begin
            f = fq.pop_front();
            check("frame_len", 32'(m_len), 32'(f.len));
            check("frame_err", 32'(m_err), 32'(f.err));
            check("incomplete_at_done", 32'(m_inc), 32'(f.inc));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    do_reset(0, 23, 759);
    idle(2);
    send_beat(32'h1234, 1'b0, 5'b0, 4'd0);
    send_beat(32'h5555, 1'b1, 5'b0, 4'd0);
    idle(3);
    send_frame(30, 0, 12, 32'hAAAB);
    send_frame(2, 0, 0, 32'hAAAB);
    send_frame(29, 0, 0, 32'hAAAB);
    send_frame(30, 5, 0, 32'hAAAB);
    send_frame(10, 10, 0, 32'hAAAB);
    send_beat(32'hAAAB, 1'b0, 5'b00011, 4'd0);
    send_beat(32'h0101, 1'b0, 5'b00011, 4'd1);
    send_beat(32'h0202, 1'b0, 5'b00011, 4'd2);
    idle(3);
    do_reset(0, 23, 759);
    send_beat(32'h0303, 1'b0, 5'b0, 4'd0);
    send_beat(32'h0404, 1'b0, 5'b0, 4'd0);
    send_beat(32'h0505, 1'b1, 5'b0, 4'd0);
    idle(3);
    send_frame(30, 0, 0, 32'hAAAB);

    do_reset(1, 2, 12);
    send_frame(8, 0, 0, 32'hAAAB);
    send_frame(9, 0, 0, 32'hAAAB);
    send_frame(12, 0, 0, 32'hAAAB);
    send_frame(27, 0, 0, 32'hAAAB);

    do_reset(2, 23, 759);
    send_beat(32'h0001AAAB, 1'b0, 5'b0, 4'd0);
    idle(2);
    send_frame(30, 0, 0, 32'h0000AAAB);
    idle(4);

    check("beats_left", 32'(bq.size()), 32'd0);
    check("frames_left", 32'(fq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_parser_fsm.md
FRAME_PARSER_FSM -- requirements
Module: frame_parser_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the ingress beat width in bits; it SHALL be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter SFD_WORD, default 16'hAAAB, meaning the start-of-frame delimiter beat value, zero-extended to DATA_W.
REQ-003 SHALL have parameters DST_WORDS, SRC_WORDS and TYPE_WORDS, defaults 3, 3 and 1, giving header field lengths in beats; each SHALL be between 1 and 15.
REQ-004 SHALL have parameter MIN_PAYLOAD_WORDS, default 23, meaning the runt threshold, and parameter MAX_FRAME_WORDS, default 759, meaning the oversize threshold.
REQ-005 Ports (name  direction  width  meaning):
 clk  in  1  clock
 reset  in  1  reset, synchronous, active-high
 s_tvalid / s_tdata / s_tlast  in  1 / DATA_W / 1  ingress AXIS source
 s_tready  out  1  ingress AXIS ready
 drop_current  in  1  downstream filter orders the current frame dropped
 almost_full  in  1  downstream buffer nearly full
 pkt_tvalid / pkt_tdata / pkt_tlast  out  1 / DATA_W / 1  registered accepted beat
 status  out  5  {scan_payload, scan_type, scan_src_mac, scan_dst_mac, scan_frame}
 field_idx  out  4  beat index within current header field
 incomplete_frame  out  1  high while in FLUSH
 frame_done  out  1  one-cycle end-of-frame pulse
 frame_err  out  3  {oversize, runt, incomplete}, valid with frame_done
 frame_len  out  16  beats after SFD through tlast, valid with frame_done

Function
REQ-006 s_tready SHALL be the registered value of ~almost_full.
REQ-007 A beat SHALL be accepted when s_tvalid and s_tready are both high.
REQ-008 pkt_tvalid SHALL equal the registered accept signal; pkt_tdata and pkt_tlast SHALL register s_tdata and s_tlast each cycle; latency SHALL be 1 cycle.
REQ-009 The FSM SHALL advance only on cycles where pkt_tvalid=1, except FLUSH, which SHALL always exit after 1 cycle.
REQ-010 States and transitions on a pkt beat:
 - IDLE: tlast -> FLUSH; tdata==SFD_WORD -> DST; else stay.
 - DST: tlast -> FLUSH; after DST_WORDS beats -> SRC.
 - SRC: tlast -> FLUSH; after SRC_WORDS beats -> TYPE.
 - TYPE: tlast -> FLUSH; after TYPE_WORDS beats -> PAYLOAD.
 - PAYLOAD: tlast -> IDLE.
 - FLUSH: -> IDLE unconditionally.
 - MASK: tlast -> IDLE.
REQ-011 field_idx SHALL increment per beat within DST, SRC and TYPE, and SHALL be 0 on field entry and in all other states.
REQ-012 drop_current SHALL have highest priority: in any non-IDLE state, the next state SHALL be IDLE if the same-cycle pkt beat has tlast, else MASK; in IDLE it SHALL be ignored.
REQ-013 frame_len SHALL count beats from the first DST beat through tlast, saturating at 16'hFFFF.
REQ-014 If frame_len exceeds MAX_FRAME_WORDS in PAYLOAD, the FSM SHALL enter MASK and latch the oversize error.
REQ-015 frame_done SHALL pulse one cycle after the tlast beat is processed in DST, SRC, TYPE, PAYLOAD, or an oversize MASK.
REQ-016 frame_done SHALL NOT pulse for IDLE tlast, for drop_current-induced exits, or for a drop_current coincident with tlast.
REQ-017 frame_err SHALL be set as follows: incomplete=1 on a header-state tlast; runt=1 when the PAYLOAD beat count including tlast is below MIN_PAYLOAD_WORDS; oversize=1 per REQ-014; frame_err SHALL be cleared on SFD detection.
REQ-018 status SHALL encode per state: IDLE/FLUSH/MASK=00000, DST=00011, SRC=00101, TYPE=01001, PAYLOAD=10001.
REQ-019 Undefined state encodings SHALL recover to IDLE on the next cycle.

Reset
REQ-020 On reset the FSM SHALL enter IDLE and all outputs SHALL be 0 (s_tready=0, pkt_*=0, status=0, field_idx=0, frame_done=0, frame_err=0, frame_len=0); all counters SHALL be cleared.
REQ-021 Reset mid-frame SHALL abandon the frame with no frame_done; the next frame SHALL require a fresh SFD.

Verification (defaults; MIN_PAYLOAD_WORDS=2, MAX_FRAME_WORDS=12 where noted)
REQ-022 Good frame: AAAB, 3 DST, 3 SRC, 1 TYPE, 23 payload with tlast on the last -> status walks 00011/00101/01001/10001, then frame_done=1, frame_len=30, frame_err=000.
REQ-023 Truncation: AAAB, 2 DST with tlast on the 2nd -> incomplete_frame=1 for 1 cycle, frame_done with frame_err=001, frame_len=2, then IDLE.
REQ-024 Runt/oversize (MIN=2, MAX=12): a 1-beat payload -> frame_err=010; a 20-beat payload -> MASK after frame_len 13, frame_done at tlast with frame_err=100.
REQ-025 Drop: drop_current in SRC without tlast -> MASK, status=00000 until tlast, no frame_done; drop_current coincident with tlast -> IDLE directly, no frame_done.
REQ-026 Backpressure: almost_full=1 -> s_tready=0 next cycle, FSM holds state and field_idx; when released, parsing resumes with no lost or duplicated beat.
REQ-027 DATA_W=32 with SFD_WORD=32'hAAAB: a good frame -> identical state sequence and frame_len to the 16-bit case.
